// File: rtl/scan_pkg.sv
// Shared types and default sizing for the scan chain bank.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package scan_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  localparam int DEF_NCHAIN     = 4;
  localparam int DEF_LEN        = 8;
  localparam int DEF_CAP_CYCLES = 1;
  localparam int DEF_PCNT_W     = 16;

  // Larger of two sizes; used to width the shared step counter.
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/scan_chain_seg.sv
// One LEN-cell scan chain: shifts serial data when se=1, loads parallel data when se=0.
// Latency: one cycle from en to updated cells.
// Backpressure: en=0 freezes every cell; no handshake.
module scan_chain_seg #(
  parameter int LEN = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           se,
  input  logic           si,
  input  logic [LEN-1:0] d,
  output logic [LEN-1:0] q
);

  // Cell 0 takes the serial input, each later cell takes its predecessor; otherwise capture d.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      if (se) begin
        q <= {q[LEN-2:0], si};
      end else begin
        q <= d;
      end
    end
  end

endmodule

// File: rtl/scan_chain_bank.sv
// Bank of NCHAIN scan chains with a shift-then-capture sequencer and a pattern counter.
// Latency: LEN shift + CAP_CYCLES capture cycles after start; done pulses the cycle after.
// Backpressure: hold freezes sequencer and cells; start while busy or held is dropped.
module scan_chain_bank
  import scan_pkg::*;
#(
  parameter int NCHAIN     = DEF_NCHAIN,
  parameter int LEN        = DEF_LEN,
  parameter int CAP_CYCLES = DEF_CAP_CYCLES,
  parameter int PCNT_W     = DEF_PCNT_W
) (
  input  logic                  C,
  input  logic                  R,
  input  logic                  start,
  input  logic                  hold,
  input  logic [NCHAIN-1:0]     si,
  input  logic [NCHAIN*LEN-1:0] d,
  output logic [NCHAIN*LEN-1:0] q,
  output logic [NCHAIN-1:0]     so,
  output logic                  se,
  output logic                  busy,
  output logic                  done,
  output logic [PCNT_W-1:0]     pat_cnt
);

  localparam int CNT_W = $clog2(max2(LEN, CAP_CYCLES) + 1);
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(LEN - 1);
  localparam logic [CNT_W-1:0] LAST_CAP   = CNT_W'(CAP_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_d;
  logic             chain_en;

  // Scan enable and busy come straight from the state register so they are glitch-free.
  assign se       = (state_q == SHIFT);
  assign busy     = (state_q == SHIFT) || (state_q == CAPTURE);
  assign chain_en = busy && !hold;

  // Next-state logic; held cycles leave state and step counter untouched.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !hold) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (!hold) begin
          if (cnt_q == LAST_SHIFT) begin
            state_d = CAPTURE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      CAPTURE: begin
        if (!hold) begin
          if (cnt_q == LAST_CAP) begin
            state_d = IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Sequencer registers, done pulse and saturating pattern counter; reset overrides everything.
  always_ff @(posedge C) begin
    if (R) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done    <= 1'b0;
      pat_cnt <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done    <= done_d;
      if (done_d && (pat_cnt != {PCNT_W{1'b1}})) begin
        pat_cnt <= pat_cnt + 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NCHAIN; k++) begin : g_chain
    scan_chain_seg #(
      .LEN(LEN)
    ) u_seg (
      .clk(C),
      .rst(R),
      .en (chain_en),
      .se (se),
      .si (si[k]),
      .d  (d[k*LEN +: LEN]),
      .q  (q[k*LEN +: LEN])
    );
    assign so[k] = q[k*LEN + LEN - 1];
  end

endmodule

// File: tb/tb_scan_chain_bank.sv
// Directed-plus-random bench for scan_chain_bank against a bit-array chain model.
// Latency: checks every cycle of each pattern.
// Backpressure: exercises hold mid-shift and start while busy/held.
module tb_scan_chain_bank;

  localparam int NCHAIN = 2;
  localparam int LEN    = 4;
  localparam int CAP    = 1;
  localparam int PCNT_W = 2;
  localparam int W      = NCHAIN * LEN;

  logic              C = 1'b0;
  logic              R;
  logic              start;
  logic              hold;
  logic [NCHAIN-1:0] si;
  logic [W-1:0]      d;
  logic [W-1:0]      q;
  logic [NCHAIN-1:0] so;
  logic              se;
  logic              busy;
  logic              done;
  logic [PCNT_W-1:0] pat_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: cell contents and completed-pattern count.
  logic [W-1:0] mq;
  int           mcnt;

  always #5 C = ~C;

  scan_chain_bank #(
    .NCHAIN(NCHAIN),
    .LEN(LEN),
    .CAP_CYCLES(CAP),
    .PCNT_W(PCNT_W)
  ) dut (
    .C(C),
    .R(R),
    .start(start),
    .hold(hold),
    .si(si),
    .d(d),
    .q(q),
    .so(so),
    .se(se),
    .busy(busy),
    .done(done),
    .pat_cnt(pat_cnt)
  );

  task automatic step();
    @(posedge C);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Each chain is an integer; a shift multiplies by two and adds the serial bit.
  function automatic logic [W-1:0] model_shift(input logic [W-1:0] cur, input logic [NCHAIN-1:0] in);
    logic [W-1:0] r;
    int           v;
    r = '0;
    for (int k = 0; k < NCHAIN; k++) begin
      v = int'(cur[k*LEN +: LEN]);
      v = ((v * 2) + int'(in[k])) % (1 << LEN);
      r[k*LEN +: LEN] = LEN'(v);
    end
    return r;
  endfunction

  function automatic logic [NCHAIN-1:0] model_so(input logic [W-1:0] cur);
    logic [NCHAIN-1:0] r;
    for (int k = 0; k < NCHAIN; k++) r[k] = cur[k*LEN + LEN - 1];
    return r;
  endfunction

  // One full pattern, entered from IDLE (or the done cycle of the previous pattern).
  task automatic run_pattern(input bit use_s0, input logic [LEN-1:0] s0,
                             input int hold_at, input int hold_len, input bit poke,
                             input logic [W-1:0] dval,
                             input bit chk_c0, input logic [LEN-1:0] exp_c0);
    int se_cnt;
    int busy_cnt;
    int exp_se;
    se_cnt   = 0;
    busy_cnt = 0;
    exp_se   = LEN + ((hold_at < LEN) ? hold_len : 0);
    start = 1'b1;
    hold  = 1'b0;
    step();
    start = 1'b0;
    for (int i = 0; i < LEN; i++) begin
      if (i == hold_at) begin
        for (int h = 0; h < hold_len; h++) begin
          hold = 1'b1;
          si   = NCHAIN'($urandom);
          if (se) se_cnt++;
          if (busy) busy_cnt++;
          check("hold_se", se, 1'b1);
          step();
          check("hold_q_frozen", q, mq);
        end
        hold = 1'b0;
      end
      si = NCHAIN'($urandom);
      if (use_s0) si[0] = s0[LEN-1-i];
      if (poke && i == 1) start = 1'b1;
      if (se) se_cnt++;
      if (busy) busy_cnt++;
      check("shift_so", so, model_so(mq));
      step();
      start = 1'b0;
      mq = model_shift(mq, si);
      check("shift_q", q, mq);
    end
    if (chk_c0) check("shift_chain0", q[LEN-1:0], exp_c0);
    for (int c = 0; c < CAP; c++) begin
      if (se) se_cnt++;
      if (busy) busy_cnt++;
      check("cap_se", se, 1'b0);
      d = dval;
      step();
    end
    mq = dval;
    if (mcnt < (1 << PCNT_W) - 1) mcnt++;
    check("cap_q", q, mq);
    check("done_pulse", done, 1'b1);
    check("done_idle", busy, 1'b0);
    check("pat_cnt", pat_cnt, 64'(mcnt));
    check("se_cycles", 64'(se_cnt), 64'(exp_se));
    check("busy_cycles", 64'(busy_cnt), 64'(exp_se + CAP));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    R = 1'b1; start = 1'b0; hold = 1'b0; si = '0; d = '0;
    mq = '0; mcnt = 0;

    // Reset state
    step();
    step();
    R = 1'b0;
    check("rst_q", q, '0);
    check("rst_so", so, '0);
    check("rst_se", se, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_pat_cnt", pat_cnt, '0);

    // Reset in the second SHIFT cycle aborts the pattern silently
    start = 1'b1;
    step();
    start = 1'b0;
    si = 2'b11;
    step();
    check("abort_se_before", se, 1'b1);
    R = 1'b1;
    step();
    R = 1'b0;
    mq = '0;
    check("abort_busy", busy, 1'b0);
    check("abort_se", se, 1'b0);
    check("abort_q", q, '0);
    check("abort_so", so, '0);
    for (int i = 0; i < 6; i++) begin
      check("abort_no_done", done, 1'b0);
      check("abort_pat_cnt", pat_cnt, '0);
      step();
    end

    // Directed shift 1,0,1,1 on chain 0, then capture 8'h5A
    run_pattern(1'b1, 4'b1011, LEN, 0, 1'b0, 8'h5A, 1'b1, 4'b1011);
    check("cap_5A", q, 8'h5A);

    // Back-to-back pattern unloads 5A (so[0] = 1,0,1,0); a start pulse while busy is dropped
    run_pattern(1'b0, '0, LEN, 0, 1'b1, W'($urandom), 1'b0, '0);
    start = 1'b0;
    step();
    check("no_queue_busy", busy, 1'b0);
    check("no_queue_done", done, 1'b0);

    // Hold three cycles mid-shift: same chain-0 result, se high seven cycles
    run_pattern(1'b1, 4'b1011, 2, 3, 1'b0, W'($urandom), 1'b1, 4'b1011);

    // Start while held in IDLE is ignored
    hold = 1'b1; start = 1'b1;
    step();
    check("held_start_busy", busy, 1'b0);
    hold = 1'b0; start = 1'b0;
    step();
    check("held_start_not_queued", busy, 1'b0);
    check("held_q", q, mq);

    // Five back-to-back random patterns; counter saturates
    R = 1'b1;
    step();
    R = 1'b0;
    mq = '0; mcnt = 0;
    check("rst2_pat_cnt", pat_cnt, '0);
    for (int p = 0; p < 5; p++) begin
      run_pattern(1'b0, '0, LEN, 0, (p == 1), W'($urandom), 1'b0, '0);
    end
    check("pat_cnt_sat", pat_cnt, 2'b11);
    step();
    check("final_done_low", done, 1'b0);
    check("final_idle", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
